// File: rtl/dbscan_stream_clusterer.sv
// Streaming 1-D DBSCAN: groups a sorted sample stream into density runs
// and reports cluster count, noise count and largest cluster per frame.
module dbscan_stream_clusterer #(
    parameter int DATA_W  = 10,
    parameter int CNT_W   = 10,
    parameter int EPS     = 0,
    parameter int MIN_PTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              frame_end,
    output logic              out_valid,
    output logic [CNT_W-1:0]  cluster_count,
    output logic [CNT_W-1:0]  noise_count,
    output logic [CNT_W-1:0]  largest_cluster,
    output logic              order_err
);

    localparam logic [DATA_W:0]  LP_EPS = (DATA_W+1)'(EPS);
    localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_PTS);
    localparam logic [CNT_W-1:0] LP_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_EMPTY, S_RUN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cl;
        logic [CNT_W-1:0] nz;
        logic [CNT_W-1:0] lg;
    } acc_t;

    // Fold a finished run of length len into the frame accumulators.
    function automatic acc_t f_close(acc_t a, logic [CNT_W-1:0] len);
        acc_t           r;
        logic [CNT_W:0] s;
        r = a;
        s = {1'b0, a.nz} + {1'b0, len};
        if (len >= LP_MIN) begin
            if (a.cl != LP_MAX) r.cl = a.cl + 1'b1;
            if (len > a.lg) r.lg = len;
        end else begin
            r.nz = s[CNT_W] ? LP_MAX : s[CNT_W-1:0];
        end
        return r;
    endfunction

    state_t            r_state;
    logic [DATA_W-1:0] r_prev;
    logic [CNT_W-1:0]  r_run_len;
    acc_t              r_acc;
    logic              r_order;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_cluster;
    logic [CNT_W-1:0]  r_noise;
    logic [CNT_W-1:0]  r_largest;
    logic              r_order_err;

    logic              w_ge;
    logic [DATA_W:0]   w_diff;
    logic              w_join;
    acc_t              w_acc1;
    acc_t              w_acc2;
    logic [CNT_W-1:0]  w_len1;
    logic              w_order;

    // Sample step first, then (for frame_end) the closing of whatever run remains.
    always_comb begin
        w_ge    = in_data >= r_prev;
        w_diff  = {1'b0, in_data} - {1'b0, r_prev};
        w_join  = (r_state == S_RUN) && w_ge && (w_diff <= LP_EPS);
        w_acc1  = r_acc;
        w_len1  = r_run_len;
        w_order = r_order | ((r_state == S_RUN) && in_valid && !w_ge);
        if (in_valid) begin
            if (w_join) begin
                w_len1 = (r_run_len == LP_MAX) ? r_run_len : r_run_len + 1'b1;
            end else begin
                if (r_state == S_RUN) w_acc1 = f_close(r_acc, r_run_len);
                w_len1 = CNT_W'(1);
            end
        end
        w_acc2 = f_close(w_acc1, w_len1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_run_len   <= '0;
            r_acc       <= '0;
            r_order     <= 1'b0;
            r_out_valid <= 1'b0;
            r_cluster   <= '0;
            r_noise     <= '0;
            r_largest   <= '0;
            r_order_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_acc     <= '0;
                        r_order   <= 1'b0;
                        r_run_len <= '0;
                        r_state   <= S_EMPTY;
                    end
                end
                S_EMPTY, S_RUN: begin
                    if (frame_start) begin
                        r_acc   <= '0;
                        r_order <= 1'b0;
                        if (in_valid) begin
                            r_prev    <= in_data;
                            r_run_len <= CNT_W'(1);
                            r_state   <= S_RUN;
                        end else begin
                            r_run_len <= '0;
                            r_state   <= S_EMPTY;
                        end
                    end else if (frame_end) begin
                        if (in_valid) r_prev <= in_data;
                        r_out_valid <= 1'b1;
                        r_cluster   <= w_acc2.cl;
                        r_noise     <= w_acc2.nz;
                        r_largest   <= w_acc2.lg;
                        r_order_err <= w_order;
                        r_acc       <= w_acc2;
                        r_order     <= w_order;
                        r_run_len   <= '0;
                        r_state     <= S_IDLE;
                    end else if (in_valid) begin
                        r_prev    <= in_data;
                        r_run_len <= w_len1;
                        r_acc     <= w_acc1;
                        r_order   <= w_order;
                        r_state   <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid       = r_out_valid;
    assign cluster_count   = r_cluster;
    assign noise_count     = r_noise;
    assign largest_cluster = r_largest;
    assign order_err       = r_order_err;

endmodule

// File: tb/tb_dbscan_stream_clusterer.sv
// Directed scoreboard bench for dbscan_stream_clusterer across three
// parameter sets (A: EPS=1/MIN=2, B: EPS=0/MIN=2, C: CNT_W=3/EPS=0/MIN=1).
module tb_dbscan_stream_clusterer;

    typedef struct {
        int cc;
        int nc;
        int lc;
        int oe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_bc;
    logic       fs [3];
    logic       iv [3];
    logic       fe [3];
    logic [9:0] d  [3];

    logic       ov_a, ov_b, ov_c;
    logic       oe_a, oe_b, oe_c;
    logic [9:0] cc_a, nc_a, lc_a;
    logic [9:0] cc_b, nc_b, lc_b;
    logic [2:0] cc_c, nc_c, lc_c;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    dbscan_stream_clusterer #(
        .DATA_W(10), .CNT_W(10), .EPS(1), .MIN_PTS(2)
    ) u_a (
        .clk(clk), .reset(rst_a), .frame_start(fs[0]), .in_valid(iv[0]),
        .in_data(d[0]), .frame_end(fe[0]), .out_valid(ov_a),
        .cluster_count(cc_a), .noise_count(nc_a),
        .largest_cluster(lc_a), .order_err(oe_a)
    );

    dbscan_stream_clusterer #(
        .DATA_W(10), .CNT_W(10), .EPS(0), .MIN_PTS(2)
    ) u_b (
        .clk(clk), .reset(rst_bc), .frame_start(fs[1]), .in_valid(iv[1]),
        .in_data(d[1]), .frame_end(fe[1]), .out_valid(ov_b),
        .cluster_count(cc_b), .noise_count(nc_b),
        .largest_cluster(lc_b), .order_err(oe_b)
    );

    dbscan_stream_clusterer #(
        .DATA_W(10), .CNT_W(3), .EPS(0), .MIN_PTS(1)
    ) u_c (
        .clk(clk), .reset(rst_bc), .frame_start(fs[2]), .in_valid(iv[2]),
        .in_data(d[2]), .frame_end(fe[2]), .out_valid(ov_c),
        .cluster_count(cc_c), .noise_count(nc_c),
        .largest_cluster(lc_c), .order_err(oe_c)
    );

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(int k, int cc, int nc, int lc, int oe);
        exp_t e;
        e.cc = cc; e.nc = nc; e.lc = lc; e.oe = oe;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic got(int k, int cc, int nc, int lc, int oe);
        exp_t e;
        int   n;
        case (k)
            0: n = q0.size();
            1: n = q1.size();
            default: n = q2.size();
        endcase
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("FAIL sb_unexpected_%0d: out_valid with %0d pending, expected >0",
                   k, n);
        end
        if (n > 0) begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("cluster_%0d", k), cc, e.cc);
            chk($sformatf("noise_%0d", k), nc, e.nc);
            chk($sformatf("largest_%0d", k), lc, e.lc);
            chk($sformatf("order_%0d", k), oe, e.oe);
        end
    endtask

    always @(negedge clk) begin
        if (ov_a) got(0, int'(cc_a), int'(nc_a), int'(lc_a), int'(oe_a));
        if (ov_b) got(1, int'(cc_b), int'(nc_b), int'(lc_b), int'(oe_b));
        if (ov_c) got(2, int'(cc_c), int'(nc_c), int'(lc_c), int'(oe_c));
    end

    // One clock of stimulus on instance k; inputs are dropped 1 ns after the edge.
    task automatic cyc(int k, logic s, logic v, int x, logic e);
        fs[k] = s;
        iv[k] = v;
        d[k]  = 10'(x);
        fe[k] = e;
        @(posedge clk);
        #1;
        fs[k] = 1'b0;
        iv[k] = 1'b0;
        d[k]  = '0;
        fe[k] = 1'b0;
    endtask

    initial begin
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fs[k] = 1'b0; iv[k] = 1'b0; fe[k] = 1'b0; d[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", int'(ov_a), 0);
        chk("rst_cc", int'(cc_a), 0);
        chk("rst_nc", int'(nc_a), 0);
        chk("rst_lc", int'(lc_a), 0);
        chk("rst_oe", int'(oe_a), 0);
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        @(posedge clk);
        #1;

        // A: 3,4,5 | 10 | 20,21 with frame_end on the last sample
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        cyc(0, 0, 1, 4, 0);
        cyc(0, 0, 1, 5, 0);
        cyc(0, 0, 1, 10, 0);
        cyc(0, 0, 1, 20, 0);
        chk("pre_ov_a", int'(ov_a), 0);
        push(0, 2, 1, 3, 0);
        cyc(0, 0, 1, 21, 1);
        chk("latency_a", int'(ov_a), 1);
        cyc(0, 0, 0, 0, 0);
        chk("pulse_a", int'(ov_a), 0);
        chk("hold_cc_a", int'(cc_a), 2);

        // B: empty frame, then 7,7,7
        cyc(1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("latency_empty", int'(ov_b), 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 7, 0);
        cyc(1, 0, 1, 7, 0);
        push(1, 1, 0, 3, 0);
        cyc(1, 0, 1, 7, 1);

        // B: 5,5,3,3 -> out-of-order, two pairs
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 5, 0);
        cyc(1, 0, 1, 5, 0);
        cyc(1, 0, 1, 3, 0);
        push(1, 2, 0, 2, 1);
        cyc(1, 0, 1, 3, 1);

        // B: order flag must clear on the next frame
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 2, 0);
        push(1, 1, 1, 2, 0);
        cyc(1, 0, 1, 2, 1);

        // C: ten isolated points, cluster count saturates at 7
        cyc(2, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(2, 0, 1, 2 * i, 0);
        push(2, 7, 0, 1, 0);
        cyc(2, 0, 1, 18, 1);

        // C: sample coincident with frame_end in an empty frame
        cyc(2, 1, 0, 0, 0);
        push(2, 1, 0, 1, 0);
        cyc(2, 0, 1, 5, 1);

        // A: abandoned frame, restart with coincident first sample
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 2, 0);
        cyc(0, 1, 1, 9, 0);
        chk("abandon_ov", int'(ov_a), 0);
        push(0, 1, 0, 2, 0);
        cyc(0, 0, 1, 9, 1);
        chk("latency_restart", int'(ov_a), 1);

        // A: asynchronous reset mid-run
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 4, 0);
        cyc(0, 0, 1, 5, 0);
        #3;
        rst_a = 1'b1;
        #1;
        chk("async_cc", int'(cc_a), 0);
        chk("async_nc", int'(nc_a), 0);
        chk("async_lc", int'(lc_a), 0);
        chk("async_oe", int'(oe_a), 0);
        #1;
        rst_a = 1'b0;
        cyc(0, 0, 1, 6, 1);
        chk("idle_fe_ov", int'(ov_a), 0);
        cyc(0, 0, 1, 7, 0);
        cyc(0, 0, 0, 0, 1);
        chk("idle_fe_ov2", int'(ov_a), 0);
        chk("idle_cc", int'(cc_a), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("drain_a", q0.size(), 0);
        chk("drain_b", q1.size(), 0);
        chk("drain_c", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbscan_stream_clusterer.md
Name: dbscan_stream_clusterer

Overview:
- Parametrised successor to the single-channel DBSCAN argument stage.
- Consumes a non-decreasing (pre-sorted) stream of 1-D samples per frame, from the SR sort chain, gated by valid.
- Groups each frame into density runs using epsilon and true minpts.
- Reports cluster count, noise count and largest cluster size per frame, with a one-cycle result strobe.

Parameters:
- DATA_W, 10, sample width in bits.
- CNT_W, 10, width of every count/size output.
- EPS, 0, max allowed difference (cur - prev) for two consecutive samples to share a run.
- MIN_PTS, 2, minimum run length (in samples) for a run to count as a cluster. Legal range is 1..2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse that opens a new frame.
- in_valid  input  1  in_data is a frame sample this cycle.
- in_data  input  DATA_W  sample value.
- frame_end  input  1  one-cycle pulse that closes the frame. If in_valid is also high, that sample is included first.
- out_valid  output  1  one-cycle strobe; result outputs are updated on this cycle.
- cluster_count  output  CNT_W  runs with length >= MIN_PTS.
- noise_count  output  CNT_W  total samples in runs shorter than MIN_PTS.
- largest_cluster  output  CNT_W  length of the longest qualifying run; 0 if none.
- order_err  output  1  sticky per frame: a sample below its predecessor was seen. Valid with out_valid.

Behaviour:
- Reset (async) clears:
  - all outputs to 0;
  - internal prev, run_len and accumulators to 0;
  - state to IDLE.
- States:
  - IDLE: in_valid and frame_end are ignored. frame_start -> EMPTY and clears the accumulators and the order flag.
  - EMPTY: frame open, no sample yet.
    - in_valid: prev <= in_data, run_len <= 1 -> RUN.
    - frame_end -> emit zeros, order_err=0 -> IDLE.
  - RUN: on in_valid:
    - diff = in_data - prev, computed at DATA_W+1 bits.
    - If in_data >= prev and diff <= EPS: run_len++.
    - Otherwise, close the run, then run_len <= 1.
    - If in_data < prev, also set the order flag.
    - prev <= in_data in both cases.
- Closing a run of length L:
  - If L >= MIN_PTS: cluster++, and largest <= max(largest, L).
  - Otherwise: noise += L.
- frame_end in RUN:
  - Apply the coincident in_valid sample first, if present.
  - Then close the current run.
  - Present the final accumulator values on the next cycle with out_valid=1 -> IDLE.
  - Latency is exactly 1 cycle from frame_end to out_valid.
- Result outputs hold their values until the next out_valid or reset. out_valid is high for exactly one cycle.
- frame_start while in EMPTY or RUN:
  - The current frame is abandoned with no out_valid.
  - Accumulators clear; state -> EMPTY.
  - A coincident in_valid is taken as the first sample of the new frame, so the state goes to RUN.
  - frame_start has priority over frame_end in the same cycle.
- Saturation: run_len, cluster, noise and largest all saturate at 2^CNT_W-1 and never wrap.
- No back-pressure: one sample per cycle is accepted whenever in_valid is high.

Test Plan:
- EPS=1, MIN_PTS=2. Frame samples 3,4,5,10,20,21, with frame_end coincident with 21 -> 1 cycle later out_valid=1, cluster_count=2, noise_count=1, largest_cluster=3, order_err=0.
- frame_start followed by frame_end with no samples -> out_valid=1, all counts 0. A second frame (7,7,7, EPS=0, MIN_PTS=2) -> clusters 1, noise 0, largest 3.
- EPS=0, MIN_PTS=2. Samples 5,5,3,3 -> order_err=1, cluster_count=2, largest_cluster=2, noise_count=0.
- CNT_W=3, EPS=0, MIN_PTS=1. Samples 0,2,4,...,18 (10 isolated points) -> cluster_count saturates at 7, largest_cluster=1.
- Samples 1,2 sent, then frame_start again, then 9,9 and frame_end -> only one out_valid: cluster_count=1, largest_cluster=2, noise_count=0.
- reset asserted asynchronously mid-RUN (between clock edges) -> outputs 0 immediately. No out_valid for that frame's later frame_end; the FSM stays in IDLE.
